div_iter: RTL and testbench

//  Multi-cycle iterative radix-2 restoring divider. It is the responder behind the EX-stage ALU's

---
 rtl/cpuDefine.sv | 17 +
 rtl/div_step.sv | 30 +++
 rtl/div_iter.sv | 135 +++++++++++++
 tb/tb_div_iter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpuDefine.sv
// Shared types for the iterative divider.
//   DATA_W      : default operand/result width
//   DType       : DATA_W-bit data word
//   div_state_e : divider sequencing states
package cpuDefine;

  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] DType;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration (purely combinational).
//   rem_i     : partial remainder (always < divisor, so WIDTH bits hold it)
//   quo_i     : dividend bits still to shift in (MSB first) / quotient bits so far
//   divisor_i : divisor magnitude
//   rem_o     : next partial remainder
//   quo_o     : next {remaining dividend, quotient} word, new quotient bit in LSB
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;
  logic           trial_ge;

  // Shifted remainder is WIDTH+1 bits; since it is below 2*divisor the
  // difference fits WIDTH+1 bits signed, so its MSB is the borrow.
  assign rem_sh   = {rem_i, quo_i[WIDTH-1]};
  assign trial    = rem_sh - {1'b0, divisor_i};
  assign trial_ge = ~trial[WIDTH];

  assign rem_o = trial_ge ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], trial_ge};

endmodule

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider, signed or unsigned, one quotient
// bit per clock. Returns quotient and remainder together.
//   aclk, aresetn       : clock, async active-low reset
//   en                  : request level, held by the ALU for the whole op
//   is_signed           : two's-complement operands/results when 1
//   dividend, divisor   : operands, sampled only at start
//   quotient, remainder : registered results, held until the next op's load
//   complete            : one-cycle pulse, results valid
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for en; latches operand magnitudes and sign info
// CALC  | WIDTH iterations; en low aborts back to IDLE, outputs kept
// DONE  | complete high for this cycle only; always returns to IDLE
module div_iter
  import cpuDefine::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             en,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             complete
);

  localparam int                CNT_W     = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             div_zero_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             complete_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign a_neg = is_signed & dividend[WIDTH-1];
  assign b_neg = is_signed & divisor[WIDTH-1];
  // The most negative value maps onto itself, which is the correct
  // unsigned magnitude, so no special case is needed.
  assign a_abs = a_neg ? (WIDTH'(0) - dividend) : dividend;
  assign b_abs = b_neg ? (WIDTH'(0) - divisor)  : divisor;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i    (rem_q),
    .quo_i    (quo_q),
    .divisor_i(dvs_q),
    .rem_o    (rem_d),
    .quo_o    (quo_d)
  );

  // With a zero divisor every trial succeeds, so the magnitude path yields
  // all-ones and |dividend|; restoring the dividend's sign on the remainder
  // gives back the dividend as presented, only the quotient is forced.
  assign quo_fix = div_zero_q ? '1 : (neg_quo_q ? (WIDTH'(0) - quo_d) : quo_d);
  assign rem_fix = neg_rem_q ? (WIDTH'(0) - rem_d) : rem_d;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      div_zero_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      complete_q  <= 1'b0;
    end else begin
      complete_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en) begin
            rem_q      <= '0;
            quo_q      <= a_abs;
            dvs_q      <= b_abs;
            neg_quo_q  <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            div_zero_q <= (divisor == '0);
            cnt_q      <= '0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          if (!en) begin
            state_q <= IDLE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_ITER) begin
              quotient_q  <= quo_fix;
              remainder_q <= rem_fix;
              complete_q  <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign complete  = complete_q;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed corner cases, abort, reset
// mid-operation, back-to-back ops and randomized signed/unsigned traffic,
// all compared every cycle against a behavioural reference.
module tb_div_iter;
  import cpuDefine::*;

  localparam int W = 32;

  logic aclk;
  logic aresetn;
  logic en;
  logic is_signed;
  DType dividend;
  DType divisor;
  DType quotient;
  DType remainder;
  logic complete;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  div_iter #(.WIDTH(W)) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .en       (en),
    .is_signed(is_signed),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .remainder(remainder),
    .complete (complete)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Arithmetic reference: C-style truncating division on 64-bit integers.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint      sa = 0;
    longint      sb = 0;
    longint      lq = 0;
    longint      lr = 0;
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  // Protocol model: an op starts on an edge where the block is idle and en
  // is high; it completes after en stays high for W more edges, results
  // visible with complete for one cycle, then one idle cycle follows.
  int          m_phase;
  int          m_left;
  logic [31:0] m_q;
  logic [31:0] m_r;
  logic [31:0] p_q;
  logic [31:0] p_r;
  logic        m_cmp;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_phase <= 0;
      m_left  <= 0;
      m_q     <= '0;
      m_r     <= '0;
      m_cmp   <= 1'b0;
    end else begin
      m_cmp <= 1'b0;
      case (m_phase)
        0: if (en) begin
          {p_q, p_r} <= ref_div(dividend, divisor, is_signed);
          m_left     <= W;
          m_phase    <= 1;
        end
        1: if (!en) begin
          m_phase <= 0;
        end else if (m_left == 1) begin
          m_q     <= p_q;
          m_r     <= p_r;
          m_cmp   <= 1'b1;
          m_phase <= 2;
        end else begin
          m_left <= m_left - 1;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge aclk) begin
    chk("complete", {31'b0, complete}, {31'b0, m_cmp});
    chk("quotient", quotient, m_q);
    chk("remainder", remainder, m_r);
  end

  task automatic wait_cmp(input bit scramble, output bit got);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge aclk);
      if (complete) begin
        got = 1'b1;
      end else if (scramble) begin
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'($urandom_range(0, 1));
      end
    end
    chk("complete_timeout", {31'b0, got}, 32'd1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [31:0] q, output logic [31:0] r, output int lat);
    bit got;
    int t0;
    @(negedge aclk);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    en        = 1'b1;
    t0        = cyc;
    wait_cmp(1'b1, got);
    lat = cyc - t0;
    q   = quotient;
    r   = remainder;
    en  = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic [31:0] q;
    logic [31:0] r;
    logic [63:0] e;
    int          lat;
    int          c1;
    int          ncmp;
    bit          got;

    vt[0] = '{32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    vt[1] = '{32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1};
    vt[2] = '{32'd5,         32'd0,         1'b0, 32'hFFFF_FFFF, 32'd5};
    vt[3] = '{32'hFFFF_FFFB, 32'd0,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
    vt[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0};
    vt[5] = '{32'hFFFF_FFFF, 32'd1,         1'b0, 32'hFFFF_FFFF, 32'd0};

    aresetn   = 1'b1;
    en        = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #2 aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    chk("reset_q", quotient, 32'd0);
    chk("reset_r", remainder, 32'd0);
    chk("reset_cmp", {31'b0, complete}, 32'd0);
    aresetn = 1'b1;

    // unsigned 100/7, latency and pulse width
    e = ref_div(32'd100, 32'd7, 1'b0);
    chk("model_100_7_q", e[63:32], 32'd14);
    chk("model_100_7_r", e[31:0], 32'd2);
    run_op(32'd100, 32'd7, 1'b0, q, r, lat);
    chk("lat_100_7", 32'(lat), 32'd33);
    chk("q_100_7", q, 32'd14);
    chk("r_100_7", r, 32'd2);
    @(negedge aclk);
    chk("pulse_width", {31'b0, complete}, 32'd0);

    // signed, divide-by-zero and overflow corners
    foreach (vt[i]) begin
      e = ref_div(vt[i].a, vt[i].b, vt[i].s);
      chk($sformatf("model_vec%0d_q", i), e[63:32], vt[i].q);
      chk($sformatf("model_vec%0d_r", i), e[31:0], vt[i].r);
      run_op(vt[i].a, vt[i].b, vt[i].s, q, r, lat);
      chk($sformatf("lat_vec%0d", i), 32'(lat), 32'd33);
      chk($sformatf("q_vec%0d", i), q, vt[i].q);
      chk($sformatf("r_vec%0d", i), r, vt[i].r);
    end

    // abort: drop en partway through the iterations
    @(negedge aclk);
    dividend  = 32'd50;
    divisor   = 32'd3;
    is_signed = 1'b0;
    en        = 1'b1;
    repeat (10) @(negedge aclk);
    en   = 1'b0;
    ncmp = 0;
    repeat (40) begin
      @(negedge aclk);
      if (complete) ncmp++;
    end
    chk("abort_no_complete", 32'(ncmp), 32'd0);
    run_op(32'd9, 32'd3, 1'b0, q, r, lat);
    chk("lat_9_3", 32'(lat), 32'd33);
    chk("q_9_3", q, 32'd3);
    chk("r_9_3", r, 32'd0);

    // reset mid-CALC, en held through release
    @(negedge aclk);
    dividend  = 32'd12345;
    divisor   = 32'd11;
    is_signed = 1'b0;
    en        = 1'b1;
    repeat (15) @(negedge aclk);
    aresetn = 1'b0;
    #1;
    chk("midreset_q", quotient, 32'd0);
    chk("midreset_r", remainder, 32'd0);
    chk("midreset_cmp", {31'b0, complete}, 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    c1 = cyc;
    wait_cmp(1'b0, got);
    chk("lat_after_reset", 32'(cyc - c1), 32'd33);
    chk("q_after_reset", quotient, 32'd1122);
    chk("r_after_reset", remainder, 32'd3);

    // back-to-back with en held: second op samples operands in the idle cycle
    dividend  = 32'd1000;
    divisor   = 32'd7;
    is_signed = 1'b0;
    wait_cmp(1'b0, got);
    c1 = cyc;
    chk("b2b_q1", quotient, 32'd142);
    chk("b2b_r1", remainder, 32'd6);
    dividend  = 32'hFFFF_FF9C;
    divisor   = 32'd9;
    is_signed = 1'b1;
    wait_cmp(1'b0, got);
    chk("b2b_spacing", 32'(cyc - c1), 32'd34);
    chk("b2b_q2", quotient, 32'hFFFF_FFF5);
    chk("b2b_r2", remainder, 32'hFFFF_FFFF);
    en = 1'b0;

    // randomized traffic
    for (int n = 0; n < 30; n++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = $urandom;
        1:       b = $urandom_range(1, 20);
        2:       b = 32'd0 - $urandom_range(1, 20);
        3:       b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom_range(1, 65535);
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 5) == 0) a = $urandom_range(0, 100);
      e = ref_div(a, b, s);
      run_op(a, b, s, q, r, lat);
      chk("rand_lat", 32'(lat), 32'd33);
      chk("rand_q", q, e[63:32]);
      chk("rand_r", r, e[31:0]);
    end

    repeat (3) @(negedge aclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
